// File: rtl/sockit_spi_pkg.sv
// Shared definitions for the SPI command/queue repackagers: IO modes, control
// field positions, widths and the word-to-lane unpack function.
package sockit_spi_pkg;

  typedef enum logic [1:0] {
    IOM_3WR  = 2'd0,
    IOM_SPI  = 2'd1,
    IOM_DUAL = 2'd2,
    IOM_QUAD = 2'd3
  } iom_t;

  localparam int unsigned SDW = 8;
  localparam int unsigned SDL = $clog2(SDW);
  localparam int unsigned CCO = 6;
  localparam int unsigned CDW = 32;
  localparam int unsigned QCO = 4;
  localparam int unsigned QDW = 4 * SDW;

  localparam int unsigned CTL_NEW     = 3;
  localparam int unsigned CTL_LST     = 2;
  localparam int unsigned CTL_IOM_MSB = 1;
  localparam int unsigned CTL_IOM_LSB = 0;
  localparam int unsigned CTL_CNT_MSB = 5;
  localparam int unsigned CTL_CNT_LSB = 4;

  // De-interleave the MSB-first command word onto the active lanes; idle lanes stay 0.
  function automatic logic [QDW-1:0] unpack(input logic [CDW-1:0] dat, input iom_t iom);
    logic [QDW-1:0] q;
    q = '0;
    for (int i = 0; i < int'(SDW); i++) begin
      case (iom)
        IOM_DUAL: begin
          q[2*SDW-1-i] = dat[CDW-1-2*i];
          q[SDW-1-i]   = dat[CDW-2-2*i];
        end
        IOM_QUAD: begin
          for (int k = 0; k < 4; k++) begin
            q[(4-k)*SDW-1-i] = dat[CDW-1-4*i-k];
          end
        end
        default: q[SDW-1-i] = dat[CDW-1-i];
      endcase
    end
    return q;
  endfunction

endpackage

// File: rtl/sockit_spi_rpo.sv
// Output-side repackager: splits each command word into 1, 2 or 4 queue
// segments according to the IO mode, feeding the SPI serializer.
module sockit_spi_rpo
  import sockit_spi_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_vld,
  input  logic [CCO-1:0] cmd_ctl,
  input  logic [CDW-1:0] cmd_dat,
  output logic           cmd_rdy,
  output logic           que_vld,
  output logic [QCO-1:0] que_ctl,
  output logic [QDW-1:0] que_dat,
  input  logic           que_rdy
);

  if (CDW != 4 * SDW) begin : g_cdw_check
    $error("sockit_spi_rpo: CDW must equal 4*SDW");
  end

  logic           cyc_vld;
  logic [1:0]     cyc_cnt;
  logic           cyc_new;
  logic           cyc_lst;
  iom_t           cyc_iom;
  logic [CDW-1:0] cyc_dat;

  logic           cmd_trn;
  logic           que_trn;
  iom_t           cmd_iom;
  logic [1:0]     cmd_cnt;

  // Quad fits a whole word in one segment, dual in at most two.
  function automatic logic [1:0] clamp_cnt(input logic [1:0] cnt, input iom_t iom);
    case (iom)
      IOM_QUAD: return 2'd0;
      IOM_DUAL: return (cnt != 2'd0) ? 2'd1 : 2'd0;
      default:  return cnt;
    endcase
  endfunction

  assign cmd_iom = iom_t'(cmd_ctl[CTL_IOM_MSB:CTL_IOM_LSB]);
  assign cmd_cnt = cmd_ctl[CTL_CNT_MSB:CTL_CNT_LSB];

  // Ready to accept while the last segment of the current word leaves.
  assign cmd_rdy = ~cyc_vld | (que_rdy & (cyc_cnt == 2'd0));
  assign cmd_trn = cmd_vld & cmd_rdy;
  assign que_trn = que_vld & que_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_vld <= 1'b0;
      cyc_cnt <= 2'd0;
      cyc_new <= 1'b0;
      cyc_lst <= 1'b0;
      cyc_iom <= IOM_3WR;
      cyc_dat <= '0;
    end else if (cmd_trn) begin
      cyc_vld <= 1'b1;
      cyc_cnt <= clamp_cnt(cmd_cnt, cmd_iom);
      cyc_new <= cmd_ctl[CTL_NEW];
      cyc_lst <= cmd_ctl[CTL_LST];
      cyc_iom <= cmd_iom;
      cyc_dat <= cmd_dat;
    end else if (que_trn) begin
      if (cyc_cnt != 2'd0) begin
        cyc_cnt <= cyc_cnt - 2'd1;
        cyc_new <= 1'b0;
        cyc_dat <= (cyc_iom == IOM_DUAL) ? (cyc_dat << (2 * SDW)) : (cyc_dat << SDW);
      end else begin
        cyc_vld <= 1'b0;
      end
    end
  end

  assign que_vld = cyc_vld;
  assign que_ctl = {cyc_new, cyc_lst & (cyc_cnt == 2'd0), cyc_iom};
  assign que_dat = unpack(cyc_dat, cyc_iom);

endmodule

// File: tb/tb_sockit_spi_rpo.sv
// Bench for sockit_spi_rpo: stream-order reference model plus directed
// literal checks for SPI, quad, dual, backpressure, back-to-back and reset.
module tb_sockit_spi_rpo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_vld = 1'b0;
  logic [5:0]  cmd_ctl = '0;
  logic [31:0] cmd_dat = '0;
  logic        cmd_rdy;
  logic        que_vld;
  logic [3:0]  que_ctl;
  logic [31:0] que_dat;
  logic        que_rdy = 1'b0;

  sockit_spi_rpo dut (
    .clk     (clk),
    .rst     (rst),
    .cmd_vld (cmd_vld),
    .cmd_ctl (cmd_ctl),
    .cmd_dat (cmd_dat),
    .cmd_rdy (cmd_rdy),
    .que_vld (que_vld),
    .que_ctl (que_ctl),
    .que_dat (que_dat),
    .que_rdy (que_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] dat;
  } seg_t;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] dat;
    logic        crdy;
    int          cyc;
  } obs_t;

  seg_t exp_q[$];
  obs_t log_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   rdy_pct  = 100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Word as a bit stream, MSB first; stream bit p goes to lane L-1-(p%L), MSB first.
  task automatic model_push(input logic [31:0] d, input logic [5:0] c);
    int    lanes, nseg, p;
    seg_t  s;
    logic [1:0] iom;
    iom   = c[1:0];
    lanes = (iom == 2'd3) ? 4 : (iom == 2'd2) ? 2 : 1;
    nseg  = (iom == 2'd3) ? 1 : (iom == 2'd2) ? ((c[5:4] != 0) ? 2 : 1) : int'(c[5:4]) + 1;
    for (int sg = 0; sg < nseg; sg++) begin
      s.dat = '0;
      for (int i = 0; i < 8; i++)
        for (int m = 0; m < lanes; m++) begin
          p = sg*8*lanes + i*lanes + m;
          s.dat[(lanes-1-m)*8 + 7 - i] = d[31-p];
        end
      s.ctl = {c[3] && sg == 0, c[2] && sg == nseg-1, iom};
      exp_q.push_back(s);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1 que_rdy = ($urandom_range(99) < rdy_pct);
  end

  logic        prev_stall = 1'b0;
  logic [3:0]  prev_ctl;
  logic [31:0] prev_dat;
  obs_t        ob;
  seg_t        e;

  // Compare process: every output segment against the model, plus stall stability.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_vld", 64'(que_vld), 64'd1);
        chk("stall_ctl", 64'(que_ctl), 64'(prev_ctl));
        chk("stall_dat", 64'(que_dat), 64'(prev_dat));
      end
      if (que_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_seg", 64'(que_dat), 64'hDEAD_0000_0000);
        end else begin
          e = exp_q[0];
          chk("model_ctl", 64'(que_ctl), 64'(e.ctl));
          chk("model_dat", 64'(que_dat), 64'(e.dat));
          if (que_rdy) void'(exp_q.pop_front());
        end
        if (que_rdy) begin
          ob.ctl = que_ctl; ob.dat = que_dat; ob.crdy = cmd_rdy; ob.cyc = cyc;
          log_q.push_back(ob);
        end
      end
      prev_stall = que_vld & ~que_rdy;
      prev_ctl   = que_ctl;
      prev_dat   = que_dat;
      if (cmd_vld && cmd_rdy) model_push(cmd_dat, cmd_ctl);
    end
  end

  task automatic send(input logic [31:0] d, input logic [5:0] c, output int t);
    logic ok;
    t = 0;
    cmd_vld = 1'b1; cmd_dat = d; cmd_ctl = c;
    do begin
      @(negedge clk); ok = cmd_rdy;
      @(posedge clk); #1; t++;
    end while (!ok && t < 500);
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    cmd_vld = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || que_vld) && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  int t, base;

  initial begin
    @(negedge clk);
    chk("rst_vld", 64'(que_vld), 64'd0);
    chk("rst_ctl", 64'(que_ctl), 64'd0);
    chk("rst_dat", 64'(que_dat), 64'd0);
    chk("rst_rdy", 64'(cmd_rdy), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // SPI, four segments on lane 0
    base = log_q.size();
    send(32'hA5C3_0F81, 6'b11_1_1_01, t);
    drain();
    chk("spi_nseg", 64'(log_q.size() - base), 64'd4);
    if (log_q.size() >= base + 4) begin
      chk("spi_s0", 64'({log_q[base].ctl,   log_q[base].dat}),   {32'd0, 4'b1001, 32'h0000_00A5});
      chk("spi_s1", 64'({log_q[base+1].ctl, log_q[base+1].dat}), {32'd0, 4'b0001, 32'h0000_00C3});
      chk("spi_s2", 64'({log_q[base+2].ctl, log_q[base+2].dat}), {32'd0, 4'b0001, 32'h0000_000F});
      chk("spi_s3", 64'({log_q[base+3].ctl, log_q[base+3].dat}), {32'd0, 4'b0101, 32'h0000_0081});
      chk("spi_crdy0", 64'(log_q[base].crdy),   64'd0);
      chk("spi_crdy3", 64'(log_q[base+3].crdy), 64'd1);
    end

    // Quad with clamped count
    base = log_q.size();
    send(32'h8000_0000, 6'b11_1_1_11, t);
    drain();
    chk("quad_nseg", 64'(log_q.size() - base), 64'd1);
    if (log_q.size() >= base + 1)
      chk("quad_s0", 64'({log_q[base].ctl, log_q[base].dat}), {32'd0, 4'b1111, 32'h8000_0000});

    // Dual, two segments
    base = log_q.size();
    send(32'hFFFF_0000, 6'b01_1_1_10, t);
    drain();
    chk("dual_nseg", 64'(log_q.size() - base), 64'd2);
    if (log_q.size() >= base + 2) begin
      chk("dual_s0", 64'({log_q[base].ctl,   log_q[base].dat}),   {32'd0, 4'b1010, 32'h0000_FFFF});
      chk("dual_s1", 64'({log_q[base+1].ctl, log_q[base+1].dat}), {32'd0, 4'b0110, 32'h0000_0000});
    end

    // Backpressure with random words
    rdy_pct = 30;
    for (int k = 0; k < 8; k++) send($urandom, 6'($urandom), t);
    drain();
    rdy_pct = 100;
    repeat (2) @(posedge clk); #1;

    // Back-to-back quad words
    base = log_q.size();
    for (int k = 0; k < 3; k++) begin
      send(32'h1357_9BDF + 32'(k), 6'b00_1_1_11, t);
      chk("b2b_accept_1cyc", 64'(t), 64'd1);
    end
    drain();
    chk("b2b_nseg", 64'(log_q.size() - base), 64'd3);
    if (log_q.size() >= base + 3) begin
      chk("b2b_gap01", 64'(log_q[base+1].cyc - log_q[base].cyc), 64'd1);
      chk("b2b_gap12", 64'(log_q[base+2].cyc - log_q[base+1].cyc), 64'd1);
    end

    // Reset mid-word after the 2nd SPI segment
    base = log_q.size();
    send(32'hA5C3_0F81, 6'b11_1_1_01, t);
    t = 0;
    while (log_q.size() < base + 2 && t < 100) begin @(posedge clk); #1; t++; end
    chk("rst_mid_reach", 64'(log_q.size() - base), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_vld", 64'(que_vld), 64'd0);
    chk("rst_mid_rdy", 64'(cmd_rdy), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    base = log_q.size();
    send(32'h1234_5678, 6'b00_1_1_01, t);
    drain();
    chk("post_rst_nseg", 64'(log_q.size() - base), 64'd1);
    if (log_q.size() >= base + 1)
      chk("post_rst_s0", 64'({log_q[base].ctl, log_q[base].dat}), {32'd0, 4'b1101, 32'h0000_0012});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
